// File: rtl/pc_sequencer.sv
// Purpose : selects the next PC source and runs the exception entry sequence (save EPC, fetch vector byte, load PC).
// Latency : 1 cycle for sequential/branch/jump/rte PC loads; 3+MEM_WAIT cycles from exception acceptance to vector PC load.
// Backpres: no flow control; requests are sampled only when idle and dropped (never queued) while busy is high.
// Ports   : clk/reset (async, active-high); request strobes fetch_done, branch_req/branch_taken, jump_req, jr_req,
//           rte_req, exc_req with exc_code; outputs mux_pc_control, pc_write, epc_write, vec_rd, vec_addr,
//           exc_cause (last accepted code) and busy (exception sequence in progress).
module pc_sequencer #(
    parameter logic [7:0] VEC_BASE = 8'd253,
    parameter int         MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_done,
    input  logic       branch_req,
    input  logic       branch_taken,
    input  logic       jump_req,
    input  logic       jr_req,
    input  logic       rte_req,
    input  logic       exc_req,
    input  logic [1:0] exc_code,
    output logic [2:0] mux_pc_control,
    output logic       pc_write,
    output logic       epc_write,
    output logic       vec_rd,
    output logic [7:0] vec_addr,
    output logic [1:0] exc_cause,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        EXC_SAVE,
        EXC_READ,
        EXC_WAIT,
        EXC_LOAD
    } state_t;

    localparam logic [2:0] MUX_EPC    = 3'b000;
    localparam logic [2:0] MUX_VEC    = 3'b001;
    localparam logic [2:0] MUX_ALUOUT = 3'b010;
    localparam logic [2:0] MUX_CONCAT = 3'b011;
    localparam logic [2:0] MUX_ALURES = 3'b100;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] mux_q, mux_d;
    logic       pc_write_q, pc_write_d;
    logic       epc_write_q, epc_write_d;
    logic       vec_rd_q, vec_rd_d;
    logic [7:0] vec_addr_q, vec_addr_d;
    logic [1:0] cause_q, cause_d;
    logic [7:0] vec_target;

    // Reserved code 11 has no vector slot of its own and shares the base entry.
    assign vec_target = (cause_q == 2'b11) ? VEC_BASE : VEC_BASE + {6'b0, cause_q};

    // Every output register holds the value belonging to state_d, so all outputs
    // change exactly one edge after the decision that produced them.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cause_d     = cause_q;
        mux_d       = MUX_ALURES;
        pc_write_d  = 1'b0;
        epc_write_d = 1'b0;
        vec_rd_d    = 1'b0;
        vec_addr_d  = 8'd0;
        case (state_q)
            IDLE: begin
                if (exc_req) begin
                    state_d     = EXC_SAVE;
                    cause_d     = exc_code;
                    epc_write_d = 1'b1;
                end else if (rte_req) begin
                    pc_write_d = 1'b1;
                    mux_d      = MUX_EPC;
                end else if (jr_req) begin
                    pc_write_d = 1'b1;
                    mux_d      = MUX_ALUOUT;
                end else if (jump_req) begin
                    pc_write_d = 1'b1;
                    mux_d      = MUX_CONCAT;
                end else if (branch_req && branch_taken) begin
                    pc_write_d = 1'b1;
                    mux_d      = MUX_ALUOUT;
                end else if (fetch_done) begin
                    pc_write_d = 1'b1;
                    mux_d      = MUX_ALURES;
                end
            end
            EXC_SAVE: begin
                state_d    = EXC_READ;
                vec_rd_d   = 1'b1;
                vec_addr_d = vec_target;
                cnt_d      = 3'(MEM_WAIT);
            end
            EXC_READ: begin
                state_d    = EXC_WAIT;
                vec_addr_d = vec_addr_q;
            end
            EXC_WAIT: begin
                // Counter enters at MEM_WAIT, so exit on 1 gives exactly MEM_WAIT wait cycles.
                if (cnt_q == 3'd1) begin
                    state_d    = EXC_LOAD;
                    cnt_d      = 3'd0;
                    pc_write_d = 1'b1;
                    mux_d      = MUX_VEC;
                end else begin
                    cnt_d      = cnt_q - 3'd1;
                    vec_addr_d = vec_addr_q;
                end
            end
            EXC_LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            cause_q     <= 2'b00;
            mux_q       <= MUX_ALURES;
            pc_write_q  <= 1'b0;
            epc_write_q <= 1'b0;
            vec_rd_q    <= 1'b0;
            vec_addr_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cause_q     <= cause_d;
            mux_q       <= mux_d;
            pc_write_q  <= pc_write_d;
            epc_write_q <= epc_write_d;
            vec_rd_q    <= vec_rd_d;
            vec_addr_q  <= vec_addr_d;
        end
    end

    assign mux_pc_control = mux_q;
    assign pc_write       = pc_write_q;
    assign epc_write      = epc_write_q;
    assign vec_rd         = vec_rd_q;
    assign vec_addr       = vec_addr_q;
    assign exc_cause      = cause_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose : checks pc_sequencer with MEM_WAIT=1 and MEM_WAIT=3 side by side against a cycle-offset reference model.
// Latency : outputs compared 1 time unit after every rising edge.
// Backpres: none; request pulses are driven one cycle at a time.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch_done, branch_req, branch_taken, jump_req, jr_req, rte_req, exc_req;
    logic [1:0] exc_code;

    logic [2:0] mux_a, mux_b;
    logic       pcw_a, pcw_b, epc_a, epc_b, vrd_a, vrd_b, busy_a, busy_b;
    logic [7:0] va_a, va_b;
    logic [1:0] cause_a, cause_b;

    pc_sequencer #(.VEC_BASE(8'd253), .MEM_WAIT(1)) dut_a (
        .clk(clk), .reset(reset), .fetch_done(fetch_done), .branch_req(branch_req),
        .branch_taken(branch_taken), .jump_req(jump_req), .jr_req(jr_req), .rte_req(rte_req),
        .exc_req(exc_req), .exc_code(exc_code), .mux_pc_control(mux_a), .pc_write(pcw_a),
        .epc_write(epc_a), .vec_rd(vrd_a), .vec_addr(va_a), .exc_cause(cause_a), .busy(busy_a)
    );

    pc_sequencer #(.VEC_BASE(8'd253), .MEM_WAIT(3)) dut_b (
        .clk(clk), .reset(reset), .fetch_done(fetch_done), .branch_req(branch_req),
        .branch_taken(branch_taken), .jump_req(jump_req), .jr_req(jr_req), .rte_req(rte_req),
        .exc_req(exc_req), .exc_code(exc_code), .mux_pc_control(mux_b), .pc_write(pcw_b),
        .epc_write(epc_b), .vec_rd(vrd_b), .vec_addr(va_b), .exc_cause(cause_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Observation vector: {mux[2:0], pc_write, epc_write, vec_rd, vec_addr[7:0], exc_cause[1:0], busy}
    localparam logic [16:0] RESET_VEC = {3'b100, 14'd0};

    int          passed = 0;
    int          total  = 0;
    int          failed = 0;
    int          cyc    = 0;
    int          mw[2]  = '{1, 3};
    int          off[2];          // 0 = idle, k = k-th cycle after exception acceptance
    logic [1:0]  mcause[2];
    logic [16:0] exp_v[2];

    function automatic logic [16:0] obs_a();
        return {mux_a, pcw_a, epc_a, vrd_a, va_a, cause_a, busy_a};
    endfunction

    function automatic logic [16:0] obs_b();
        return {mux_b, pcw_b, epc_b, vrd_b, va_b, cause_b, busy_b};
    endfunction

    function automatic logic [7:0] vec_of(logic [1:0] c);
        logic [7:0] r;
        r = (c == 2'b11) ? 8'd253 : 8'd253 + {6'd0, c};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] e);
        total++;
        assert (obs === e) passed++;
        else begin
            failed++;
            $error("FAIL %s cycle=%0d observed=%05h expected=%05h", tag, cyc, obs, e);
        end
    endtask

    // Reference: an exception occupies cycles 1..3+MEM_WAIT after acceptance:
    // 1 save EPC, 2 issue read, 3..2+MEM_WAIT wait, 3+MEM_WAIT load PC from vector.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int         last;
            logic       pcw, epc, vrd, bsy;
            logic [2:0] mux;
            logic [7:0] va;
            last = 3 + mw[i];
            pcw = 1'b0; epc = 1'b0; vrd = 1'b0; bsy = 1'b0; mux = 3'b100; va = 8'd0;
            if (off[i] > 0) begin
                off[i] = (off[i] == last) ? 0 : off[i] + 1;
            end else if (exc_req) begin
                off[i] = 1;
                mcause[i] = exc_code;
            end else if (rte_req) begin
                pcw = 1'b1; mux = 3'b000;
            end else if (jr_req) begin
                pcw = 1'b1; mux = 3'b010;
            end else if (jump_req) begin
                pcw = 1'b1; mux = 3'b011;
            end else if (branch_req && branch_taken) begin
                pcw = 1'b1; mux = 3'b010;
            end else if (fetch_done) begin
                pcw = 1'b1; mux = 3'b100;
            end
            if (off[i] > 0) begin
                bsy = 1'b1;
                epc = (off[i] == 1);
                vrd = (off[i] == 2);
                if (off[i] >= 2 && off[i] <= 2 + mw[i]) va = vec_of(mcause[i]);
                if (off[i] == last) begin
                    pcw = 1'b1; mux = 3'b001;
                end
            end
            exp_v[i] = {mux, pcw, epc, vrd, va, mcause[i], bsy};
        end
    endtask

    task automatic clear_req();
        fetch_done = 0; branch_req = 0; branch_taken = 0; jump_req = 0;
        jr_req = 0; rte_req = 0; exc_req = 0; exc_code = 2'b00;
    endtask

    // One clock: model advances on the same edge the DUTs sample, then both are compared.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        chk({tag, "_a"}, obs_a(), exp_v[0]);
        chk({tag, "_b"}, obs_b(), exp_v[1]);
        clear_req();
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    initial begin
        clear_req();
        reset = 1'b1;
        off[0] = 0; off[1] = 0; mcause[0] = 2'b00; mcause[1] = 2'b00;
        #3;
        chk("reset_a", obs_a(), RESET_VEC);
        chk("reset_b", obs_b(), RESET_VEC);
        @(posedge clk);
        #1 reset = 1'b0;

        // Sequential fetch: one pc_write pulse with ALUresult, then nothing.
        fetch_done = 1; cycle("fetch");
        chk("fetch_pulse", {14'd0, pcw_a, mux_a}, {14'd0, 1'b1, 3'b100});
        cycle("fetch_after");
        chk("fetch_drop", {16'd0, pcw_a}, 17'd0);

        // Taken branch outranks fetch; not-taken branch writes nothing.
        branch_req = 1; branch_taken = 1; fetch_done = 1; cycle("br_taken");
        chk("br_taken_mux", {14'd0, pcw_a, mux_a}, {14'd0, 1'b1, 3'b010});
        branch_req = 1; branch_taken = 0; cycle("br_not");
        chk("br_not_pcw", {16'd0, pcw_a}, 17'd0);
        jr_req = 1; jump_req = 1; cycle("jr_over_jump");
        jump_req = 1; fetch_done = 1; cycle("jump");

        // Exception with simultaneous jump: jump discarded, vector 254, load at +4.
        exc_req = 1; exc_code = 2'b01; jump_req = 1; cycle("exc01_save");
        chk("exc01_epc", {16'd0, epc_a}, 17'd1);
        cycle("exc01_read");
        chk("exc01_vrd", {8'd0, vrd_a, va_a}, {8'd0, 1'b1, 8'd254});
        cycle("exc01_wait");
        cycle("exc01_load");
        chk("exc01_pcw", {14'd0, pcw_a, mux_a}, {14'd0, 1'b1, 3'b001});
        chk("exc01_cause", {15'd0, cause_a}, 17'd1);
        idle(3, "exc01_tail");

        // rte during the wait phase is ignored; after the sequence it loads EPC.
        exc_req = 1; exc_code = 2'b00; cycle("rte_save");
        idle(2, "rte_pre");
        rte_req = 1; exc_req = 1; exc_code = 2'b10; cycle("rte_in_wait");
        idle(6, "rte_drain");
        chk("rte_idle_b", {16'd0, busy_b}, 17'd0);
        rte_req = 1; cycle("rte_taken");
        chk("rte_mux", {14'd0, pcw_a, mux_a}, {14'd0, 1'b1, 3'b000});

        // Reserved code uses the base vector.
        exc_req = 1; exc_code = 2'b11; cycle("exc11_save");
        cycle("exc11_read");
        chk("exc11_addr", {9'd0, va_a}, {9'd0, 8'd253});
        idle(6, "exc11_tail");

        // Divide by zero with MEM_WAIT=3: vector 255, PC load exactly 6 cycles after acceptance.
        exc_req = 1; exc_code = 2'b10; cycle("exc10_1");
        for (int k = 2; k <= 6; k++) begin
            cycle("exc10_seq");
            if (k == 2) chk("exc10_addr", {9'd0, va_b}, {9'd0, 8'd255});
            if (k == 5) chk("exc10_early", {16'd0, pcw_b}, 17'd0);
        end
        chk("exc10_pcw", {14'd0, pcw_b, mux_b}, {14'd0, 1'b1, 3'b001});
        idle(2, "exc10_tail");

        // Asynchronous reset while in the read phase.
        exc_req = 1; exc_code = 2'b10; cycle("ares_save");
        cycle("ares_read");
        #2 reset = 1'b1;
        #1;
        chk("ares_now_a", obs_a(), RESET_VEC);
        chk("ares_now_b", obs_b(), RESET_VEC);
        off[0] = 0; off[1] = 0; mcause[0] = 2'b00; mcause[1] = 2'b00;
        @(posedge clk);
        #1;
        chk("ares_hold_a", obs_a(), RESET_VEC);
        reset = 1'b0;
        idle(8, "ares_quiet");

        // Randomized traffic, sparse exceptions so both sequences and idle requests get exercised.
        for (int n = 0; n < 400; n++) begin
            exc_req      = ($urandom_range(0, 9) == 0);
            exc_code     = 2'($urandom_range(0, 3));
            rte_req      = ($urandom_range(0, 7) == 0);
            jr_req       = ($urandom_range(0, 7) == 0);
            jump_req     = ($urandom_range(0, 5) == 0);
            branch_req   = ($urandom_range(0, 3) == 0);
            branch_taken = 1'($urandom_range(0, 1));
            fetch_done   = 1'($urandom_range(0, 1));
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter VEC_BASE, default 8'd253, byte address of the first exception-vector byte.
REQ-002 Parameter MEM_WAIT, default 1, memory read wait cycles between vector address issue and vector byte valid (range 1..7).
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fetch_done  input  1  PC+4 available on ALUresult; request sequential PC update.
REQ-006 branch_req  input  1  branch instruction resolved this cycle.
REQ-007 branch_taken  input  1  branch condition true; qualifies branch_req.
REQ-008 jump_req  input  1  J/JAL target available on concatOut.
REQ-009 jr_req  input  1  register-jump target available on ALUOut.
REQ-010 rte_req  input  1  return from exception; target is EPCOut.
REQ-011 exc_req  input  1  exception raised this cycle.
REQ-012 exc_code  input  2  00 invalid opcode, 01 overflow, 10 divide by zero, 11 reserved.
REQ-013 mux_pc_control  output  3  PC source select: 000 EPC, 001 vector byte (zero-extended), 010 ALUOut, 011 concatOut, 100 ALUresult.
REQ-014 pc_write  output  1  PC register load enable.
REQ-015 epc_write  output  1  EPC register load enable.
REQ-016 vec_rd  output  1  memory read strobe for vector byte.
REQ-017 vec_addr  output  8  vector byte address.
REQ-018 exc_cause  output  2  latched exc_code of last accepted exception.
REQ-019 busy  output  1  exception sequence in progress.

Function
REQ-020 States: IDLE, EXC_SAVE, EXC_READ, EXC_WAIT, EXC_LOAD.
REQ-021 In IDLE, requests sampled each rising edge; priority exc_req > rte_req > jr_req > jump_req > (branch_req & branch_taken) > fetch_done.
REQ-022 Accepted non-exception request: in the following cycle, pc_write=1 for exactly one cycle, mux_pc_control = 000 / 010 / 011 / 010 / 100 for rte / jr / jump / taken branch / fetch respectively; outputs registered, latency 1.
REQ-023 branch_req with branch_taken=0 and no other request: no pc_write.
REQ-024 Cycles without pc_write: mux_pc_control = 100, epc_write=0, vec_rd=0.
REQ-025 Accepted exc_req: latch exc_code into exc_cause, go to EXC_SAVE; lower-priority requests in the same cycle are discarded.
REQ-026 EXC_SAVE (1 cycle): epc_write=1, busy=1.
REQ-027 EXC_READ (1 cycle): vec_rd=1, vec_addr = VEC_BASE + {0,exc_cause} for codes 00..10, VEC_BASE for code 11; wait counter loaded with MEM_WAIT.
REQ-028 EXC_WAIT: vec_addr held, vec_rd=0, counter decrements each cycle; exit to EXC_LOAD when counter reaches 1 (exactly MEM_WAIT cycles in EXC_WAIT).
REQ-029 EXC_LOAD (1 cycle): mux_pc_control=001, pc_write=1, busy=1; next state IDLE.
REQ-030 busy=1 in all non-IDLE states; all requests, including exc_req, ignored while busy (no nesting, no queueing).
REQ-031 vec_addr = 0 outside EXC_READ/EXC_WAIT; arithmetic 8-bit, no wrap permitted for VEC_BASE <= 8'd253.
REQ-032 Exception total latency: pc_write for vector load occurs 3+MEM_WAIT cycles after acceptance edge.

Reset
REQ-033 reset asserted: immediately (no clock) state=IDLE, pc_write=0, epc_write=0, vec_rd=0, vec_addr=0, busy=0, exc_cause=00, mux_pc_control=100, counter=0.
REQ-034 reset mid-exception-sequence aborts it; no pc_write or epc_write pulse after reset assertion; first request sampled on first rising edge after reset deassertion.

Verification
REQ-035 fetch_done=1 one cycle -> next cycle pc_write=1, mux_pc_control=100; following cycle pc_write=0.
REQ-036 branch_req=1, branch_taken=1, fetch_done=1 same cycle -> single pc_write with mux_pc_control=010; branch_taken=0 -> pc_write=0.
REQ-037 exc_req=1, exc_code=01, jump_req=1, MEM_WAIT=1 -> epc_write cycle+1, vec_rd with vec_addr=254 cycle+2, wait cycle+3, pc_write with mux=001 cycle+4; jump never taken; exc_cause=01.
REQ-038 rte_req pulsed during EXC_WAIT -> ignored; after return to IDLE, rte_req -> pc_write with mux=000.
REQ-039 exc_code=11 -> vec_addr=253; exc_code=10 with MEM_WAIT=3 -> vec_addr=255, pc_write 6 cycles after acceptance.
REQ-040 reset asserted asynchronously in EXC_READ -> all outputs at reset values before next edge; no later epc_write/pc_write without new request.
